// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for an 8-bit instruction memory: owns the PC, registers each fetched
// byte into a one-entry valid/ready buffer, and handles run/halt, branches and retire counting.
module imem_fetch_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 6,
  parameter int WRAP_EN   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              running,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retired_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic              WRAP      = (WRAP_EN != 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic [15:0]         cnt_q, cnt_d;

  logic fetch_en_s;
  logic consume_s;
  logic flush_s;

  assign fetch_en_s = (state_q == ST_RUN) && !halt_req && !branch_valid &&
                      (!valid_q || instr_ready);
  assign consume_s  = valid_q && instr_ready;
  // A branch drops the buffered instruction even when decode is ready, so it is not retired.
  assign flush_s    = (state_q == ST_RUN) && branch_valid && !halt_req;

  // Next-state, PC, buffer and counter computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;

    if (consume_s && !flush_s) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (consume_s && !fetch_en_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = {ADDR_W{1'b0}};
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (branch_valid) begin
          valid_d = 1'b0;
          if (branch_target <= LAST_ADDR) begin
            pc_d = branch_target;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else if (fetch_en_s) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          // Without wrap the PC parks on the last word and the sequencer stops.
          if (pc_q == LAST_ADDR) begin
            if (WRAP) begin
              pc_d = {ADDR_W{1'b0}};
            end else begin
              state_d = ST_HALT;
            end
          end else begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= {ADDR_W{1'b0}};
      instr_q    <= {DATA_W{1'b0}};
      instr_pc_q <= {ADDR_W{1'b0}};
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign fault       = fault_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the 8-bit instruction memory. It owns the program counter and drives the memory's address. Each fetched byte is registered into a single-entry output buffer with a valid/ready handshake toward decode. It also handles run/halt control, branch redirects, out-of-range detection and an accepted-instruction counter.

## Interface
- `ADDR_W`, 8, width of the program counter and memory address.
- `DATA_W`, 8, instruction width.
- `MEM_DEPTH`, 6, number of populated memory words; valid addresses are 0..MEM_DEPTH-1.
- `WRAP_EN`, 0, 1 = PC wraps to 0 after the last word; 0 = halt after the last word.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins fetching from address 0.
- `halt_req` in 1: one-cycle pulse; stops fetching.
- `branch_valid` in 1: redirect request.
- `branch_target` in ADDR_W: redirect address.
- `imem_addr` out ADDR_W: address to the instruction memory; combinationally equals `pc`.
- `imem_data` in DATA_W: the memory's combinational read data.
- `instr` out DATA_W: buffered instruction.
- `instr_pc` out ADDR_W: address `instr` was fetched from.
- `instr_valid` out 1: buffer holds an instruction.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `running` out 1: state == RUN.
- `halted` out 1: state == HALT.
- `fault` out 1: sticky; a branch target was >= MEM_DEPTH.
- `retired_cnt` out 16: count of handshakes (`instr_valid && instr_ready`); saturates at 0xFFFF.

## Operation
- States are IDLE, RUN and HALT.
- **Reset (async, immediate):**
  - State goes to IDLE.
  - `pc`, `instr`, `instr_pc` and `retired_cnt` clear to 0.
  - `instr_valid`, `fault`, `running` and `halted` clear to 0.
  - Reset asserted mid-RUN discards the buffered instruction.
- **IDLE / HALT + `start`:**
  - Go to RUN with `pc` = 0.
  - Clear `instr_valid` and `fault`.
  - `retired_cnt` is kept.
  - `start` in RUN is ignored.
- **Fetch enable:** `fetch_en = RUN && !halt_req && !branch_valid && (!instr_valid || instr_ready)`.
- **Fetch:**
  - `instr` <= `imem_data`, `instr_pc` <= `pc`, `instr_valid` <= 1.
  - If `pc` == MEM_DEPTH-1: with WRAP_EN=1, `pc` <= 0; with WRAP_EN=0, `pc` is held and the state goes to HALT.
  - Otherwise `pc` <= `pc` + 1, modulo 2^ADDR_W.
- **Consume without refill:** `instr_valid && instr_ready && !fetch_en` gives `instr_valid` <= 0. This applies in every state.
- **Stall:** `instr_valid && !instr_ready` holds `instr`, `instr_pc` and `pc` unchanged.
- **Branch** (RUN, `branch_valid`, no `halt_req`):
  - `instr_valid` <= 0; the buffered instruction is flushed even if `instr_ready` is high.
  - A flushed instruction is not counted.
  - If `branch_target` < MEM_DEPTH, `pc` <= `branch_target` and the state stays in RUN.
  - Otherwise `fault` <= 1, `pc` is unchanged and the state goes to HALT.
- **`halt_req`** (RUN): no fetch; the state goes to HALT. A valid buffered instruction stays available until consumed.
- **Priority in RUN:** `halt_req` > `branch_valid` > fetch. In IDLE and HALT, `branch_valid` and `halt_req` are ignored.

## Timing
- **Fetch latency:** one cycle. `imem_addr` = a in cycle N gives `instr` = mem[a] and `instr_valid` = 1 in N+1.
- **Throughput:** one instruction per cycle with `instr_ready` tied high.
- **Start:** the pulse in cycle N puts the state in RUN at N+1. The first fetch (addr 0) happens at N+1, and `instr_valid` rises at N+2.
- **Branch:** the pulse in cycle N gives `instr_valid` = 0 at N+1 with `imem_addr` = target. mem[target] is valid at N+2.
- **End of memory (WRAP_EN=0):** `halted` rises in the cycle the last instruction becomes valid. The last instruction is still delivered.
- **Registered outputs:** all outputs except `imem_addr` are registered. `running` and `halted` are decoded from the state register.
- **Counter:** `retired_cnt` increments in the cycle after the handshake.

## Test plan
Memory contents are 0x11, 0x22, 0x33, 0x44, 0x55, 0x66.
- **Basic run:** reset, then `start`, `instr_ready` = 1. Expect `instr` 0x11..0x66 on `instr_pc` 0..5 in consecutive cycles, `halted` = 1 with 0x66 valid, then `instr_valid` = 0 and `retired_cnt` = 6.
- **Backpressure:** hold `instr_ready` = 0 for 3 cycles while 0x22 is buffered. Expect `instr` = 0x22 and `imem_addr` = 2 stable throughout; 0x33 follows the cycle after `instr_ready` returns.
- **Branch:**
  - Pulse `branch_valid` with target 4 while 0x22 is valid. Expect 0x22 flushed (not counted) and the next valid `instr` = 0x55, `instr_pc` = 4.
  - Target 9: expect `fault` = 1, `halted` = 1, no further fetches.
- **Wrap:** with WRAP_EN=1, expect 0x66 then 0x11, `instr_pc` 5 then 0.
- **Halt/restart:** pulse `halt_req` mid-run. Expect no new fetch and the buffered instruction still delivered. `start` then restarts at 0x11 and clears `fault`.
- **Async reset:** assert `reset_n` = 0 mid-stall, between clock edges. Expect all outputs 0 immediately and the state IDLE.
